// File: rtl/trip_pkg.sv
// trip_pkg: controller state encoding and default timing/circumference constants
package trip_pkg;
  typedef enum logic [1:0] {RUN, EDIT, COMMIT} state_t;
  localparam logic [7:0] DEF_CIRC_DEFAULT = 8'd220;
  localparam logic [7:0] DEF_CIRC_MIN = 8'd150;
  localparam logic [7:0] DEF_CIRC_MAX = 8'd250;
  localparam int DEF_LOCKOUT_CYCLES = 50;
  localparam int DEF_LONG_PRESS = 2000;
  localparam int DEF_REPEAT_DELAY = 500;
  localparam int DEF_REPEAT_RATE = 100;
  localparam int DEF_EDIT_TIMEOUT = 10000;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: 2-flop synchroniser with registered level history and rising-edge pulse
module edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic s1, s2;
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      level <= s2;
      rise <= s2 & ~level;
    end
  end
endmodule

// File: rtl/trip_ctrl.sv
// trip_ctrl: reed pulse qualification, trip clear and circumference edit FSM
module trip_ctrl
  import trip_pkg::*;
#(
  parameter logic [7:0] CIRC_DEFAULT = DEF_CIRC_DEFAULT,
  parameter logic [7:0] CIRC_MIN = DEF_CIRC_MIN,
  parameter logic [7:0] CIRC_MAX = DEF_CIRC_MAX,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int LONG_PRESS = DEF_LONG_PRESS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE,
  parameter int EDIT_TIMEOUT = DEF_EDIT_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reed_raw,
  input  logic       btn_mode,
  input  logic       btn_set,
  output logic [7:0] circ,
  output logic       reed_pulse,
  output logic       dist_clear,
  output logic       edit,
  output logic [7:0] edit_circ
);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int IW = $clog2(EDIT_TIMEOUT + 1);
  localparam logic [LW-1:0] LOCK_N = LW'(LOCKOUT_CYCLES);
  localparam logic [HW-1:0] HOLD_N = HW'(LONG_PRESS);
  localparam logic [RW-1:0] REP_D = RW'(REPEAT_DELAY);
  // reload so the next fire lands exactly REPEAT_RATE cycles later
  localparam logic [RW-1:0] REP_R = RW'(REPEAT_DELAY - REPEAT_RATE + 1);
  localparam logic [IW-1:0] IDLE_N = IW'(EDIT_TIMEOUT);
  state_t state;
  logic reed_lvl, reed_rise, mode_lvl, mode_rise, set_lvl, set_rise;
  logic [LW-1:0] lockout;
  logic [HW-1:0] hold;
  logic [RW-1:0] rep;
  logic [IW-1:0] idle;
  logic [7:0] wrap;
  edge_sync u_reed (.clock(clock), .reset(reset), .async_in(reed_raw), .level(reed_lvl), .rise(reed_rise));
  edge_sync u_mode (.clock(clock), .reset(reset), .async_in(btn_mode), .level(mode_lvl), .rise(mode_rise));
  edge_sync u_set (.clock(clock), .reset(reset), .async_in(btn_set), .level(set_lvl), .rise(set_rise));
  always_comb wrap = edit_circ == CIRC_MAX ? CIRC_MIN : edit_circ + 8'd1;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      circ <= CIRC_DEFAULT;
      edit_circ <= CIRC_DEFAULT;
      reed_pulse <= 1'b0;
      dist_clear <= 1'b0;
      edit <= 1'b0;
      lockout <= '0;
      hold <= '0;
      rep <= '0;
      idle <= '0;
    end else begin
      reed_pulse <= reed_rise && lockout == '0 && state == RUN && hold != HOLD_N;
      lockout <= (reed_rise && lockout == '0) ? LOCK_N : (lockout != '0 ? lockout - 1'b1 : lockout);
      dist_clear <= 1'b0;
      hold <= (state == RUN && mode_lvl) ? (hold == HOLD_N ? hold : hold + 1'b1) : '0;
      rep <= (state == EDIT && set_lvl) ? (rep == REP_D ? REP_R : rep + 1'b1) : '0;
      idle <= (state == EDIT && !(set_rise || mode_rise)) ? idle + 1'b1 : '0;
      case (state)
        RUN: begin
          edit_circ <= circ;
          dist_clear <= set_rise;
          if (hold == HOLD_N) begin
            state <= EDIT;
            edit <= 1'b1;
          end
        end
        EDIT: begin
          if (mode_rise) begin
            state <= COMMIT;
            edit <= 1'b0;
            circ <= edit_circ;
            dist_clear <= 1'b1;
          end else if (idle == IDLE_N) begin
            state <= RUN;
            edit <= 1'b0;
            edit_circ <= circ;
          end else if (set_rise || (set_lvl && rep == REP_D)) begin
            edit_circ <= wrap;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_trip_ctrl.sv
// tb_trip_ctrl: directed vectors for trip_ctrl with reduced timing parameters
module tb_trip_ctrl;
  logic clock, reset, reed_raw, btn_mode, btn_set;
  logic [7:0] circ, edit_circ;
  logic reed_pulse, dist_clear, edit;
  int tests = 0, fails = 0, pulses = 0, clears = 0, base;

  trip_ctrl #(
    .LOCKOUT_CYCLES(5), .LONG_PRESS(8), .REPEAT_DELAY(6), .REPEAT_RATE(3), .EDIT_TIMEOUT(40)
  ) dut (
    .clock(clock), .reset(reset), .reed_raw(reed_raw), .btn_mode(btn_mode), .btn_set(btn_set),
    .circ(circ), .reed_pulse(reed_pulse), .dist_clear(dist_clear), .edit(edit), .edit_circ(edit_circ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reed_pulse) pulses++;
    if (dist_clear) clears++;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press();
    btn_set = 1'b1;
    tick(1);
    btn_set = 1'b0;
    tick(1);
  endtask

  task automatic enter_edit();
    btn_mode = 1'b1;
    tick(8);
    btn_mode = 1'b0;
    tick(6);
  endtask

  initial begin
    reset = 1'b1;
    reed_raw = 1'b0;
    btn_mode = 1'b0;
    btn_set = 1'b0;
    tick(3);
    check("rst_circ", circ, 220);
    check("rst_edit_circ", edit_circ, 220);
    check("rst_edit", edit, 0);
    check("rst_reed_pulse", reed_pulse, 0);
    check("rst_dist_clear", dist_clear, 0);
    reset = 1'b0;
    tick(2);
    // reed latency: first sampled edge k, pulse after edge k+3, one cycle wide
    reed_raw = 1'b1;
    tick(2);
    reed_raw = 1'b0;
    tick(1);
    check("reed_lat_early", reed_pulse, 0);
    tick(1);
    check("reed_lat_k3", reed_pulse, 1);
    tick(1);
    check("reed_width", reed_pulse, 0);
    tick(5);
    base = pulses;
    reed_raw = 1'b1;
    tick(2);
    reed_raw = 1'b0;
    tick(8);
    check("reed_spaced", pulses - base, 1);
    base = pulses;
    reed_raw = 1'b1;
    tick(2);
    reed_raw = 1'b0;
    tick(1);
    reed_raw = 1'b1;
    tick(2);
    reed_raw = 1'b0;
    tick(10);
    check("reed_lockout_drop", pulses - base, 1);
    reed_raw = 1'b1;
    reset = 1'b1;
    tick(3);
    check("reed_held_rst_none", reed_pulse, 0);
    base = pulses;
    reset = 1'b0;
    tick(10);
    check("reed_held_one", pulses - base, 1);
    check("reed_held_circ", circ, 220);
    check("reed_held_edit", edit, 0);
    check("reed_held_clear", dist_clear, 0);
    reed_raw = 1'b0;
    tick(10);
    base = clears;
    btn_set = 1'b1;
    tick(2);
    btn_set = 1'b0;
    tick(6);
    check("run_set_clear", clears - base, 1);
    btn_mode = 1'b1;
    tick(7);
    btn_mode = 1'b0;
    tick(6);
    check("hold7_no_edit", edit, 0);
    enter_edit();
    check("hold8_edit", edit, 1);
    check("hold8_edit_circ", edit_circ, 220);
    // auto-repeat: edge, +6 cycles, then every 3
    btn_set = 1'b1;
    tick(4);
    check("rep_edge", edit_circ, 221);
    tick(5);
    check("rep_no_early", edit_circ, 221);
    tick(1);
    check("rep_delay", edit_circ, 222);
    tick(3);
    check("rep_rate1", edit_circ, 223);
    btn_set = 1'b0;
    tick(3);
    check("rep_rate2", edit_circ, 224);
    tick(5);
    check("rep_release", edit_circ, 224);
    check("rep_circ_kept", circ, 220);
    base = clears;
    btn_mode = 1'b1;
    tick(2);
    btn_mode = 1'b0;
    tick(4);
    check("commit_circ", circ, 224);
    check("commit_edit", edit, 0);
    check("commit_clear", clears - base, 1);
    check("commit_edit_circ", edit_circ, 224);
    enter_edit();
    repeat (26) press();
    tick(4);
    check("wrap_at_max", edit_circ, 250);
    press();
    tick(4);
    check("wrap_to_min", edit_circ, 150);
    base = pulses;
    reed_raw = 1'b1;
    tick(2);
    reed_raw = 1'b0;
    tick(10);
    check("edit_reed_blocked", pulses - base, 0);
    btn_set = 1'b1;
    btn_mode = 1'b1;
    tick(2);
    btn_set = 1'b0;
    btn_mode = 1'b0;
    tick(4);
    check("simul_circ", circ, 150);
    check("simul_edit_circ", edit_circ, 150);
    check("simul_edit", edit, 0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    enter_edit();
    repeat (10) press();
    tick(4);
    check("tmo_edit_circ", edit_circ, 230);
    base = clears;
    tick(30);
    check("tmo_still_edit", edit, 1);
    tick(15);
    check("tmo_edit", edit, 0);
    check("tmo_circ", circ, 220);
    check("tmo_edit_circ_back", edit_circ, 220);
    check("tmo_no_clear", clears - base, 0);
    enter_edit();
    press();
    tick(4);
    check("mid_edit_221", edit_circ, 221);
    reset = 1'b1;
    tick(2);
    check("rst_mid_edit", edit, 0);
    check("rst_mid_edit_circ", edit_circ, 220);
    reset = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
